sram_rport_arbiter: RTL

- Arbitrates the read-only second port (csb1/addr1) of the cache SRAM macro banks between two requesters: the Caravel Wishbone slave (management SoC debug reads) and a Logic-Analyzer strobe interface.
- Sequences each granted read through a fixed macro read latency, captures the selected bank's data and returns it with a single-cycle acknowledge.
- Sits in the Marmot user-project wrapper, in front of the data/tag array macros' port 1. It replaces the direct LA-driven csb1/addr1 wiring and the dummy Wishbone ack.

---
 rtl/sram_rport_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_rport_arbiter.sv
// Port-1 arbiter for the cache SRAM macro banks: Wishbone debug reads and LA strobe reads
// share csb1/addr1; each granted read is sequenced through the macro latency and acked once.
module sram_rport_arbiter #(
  parameter int          NBANK     = 8,
  parameter int          AW        = 9,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          READ_LAT  = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                la_req_i,
  input  logic [2:0]          la_bank_i,
  input  logic [AW-1:0]       la_addr_i,
  output logic                la_ack_o,
  output logic [DW-1:0]       la_rdata_o,
  output logic [NBANK-1:0]    ram_csb1_o,
  output logic [AW-1:0]       ram_addr1_o,
  input  logic [NBANK*DW-1:0] ram_rdata_i,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;
  localparam logic [1:0] WAIT_INIT = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;
  localparam logic [3:0] NBANK_L   = 4'(NBANK);

  logic [1:0]       state;
  logic [1:0]       wait_cnt;
  logic [2:0]       bank_q;
  logic             grant_la_q;
  logic             wb_abort_q;
  logic             favour_la;
  logic             wb_hit;
  logic             grant_la;
  logic             grant_wb;
  logic             sel_fast;
  logic             complete;
  logic [2:0]       wb_bank;
  logic [2:0]       sel_bank;
  logic [AW-1:0]    wb_word;
  logic [AW-1:0]    sel_word;
  logic [NBANK-1:0] csb_issue;
  logic [DW-1:0]    rd_sel;
  logic             unused_adr;

  assign wb_hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign wb_bank  = wbs_adr_i[AW+4:AW+2];
  assign wb_word  = wbs_adr_i[AW+1:2];

  // LA wins when it is alone or when the round-robin pointer favours it
  assign grant_la = la_req_i & (~wb_hit | favour_la);
  assign grant_wb = wb_hit & ~grant_la;
  assign sel_bank = grant_la ? la_bank_i : wb_bank;
  assign sel_word = grant_la ? la_addr_i : wb_word;
  assign sel_fast = grant_la ? ({1'b0, la_bank_i} >= NBANK_L)
                             : (wbs_we_i | ({1'b0, wb_bank} >= NBANK_L));

  assign complete = ((state == S_ISSUE) && (READ_LAT == 1)) ||
                    ((state == S_WAIT) && (wait_cnt == 2'd0));
  assign busy_o     = (state != S_IDLE);
  assign unused_adr = ^{wbs_adr_i[15:AW+5], wbs_adr_i[1:0]};

  always_comb begin
    csb_issue = '1;
    for (int b = 0; b < NBANK; b++)
      if (sel_bank == 3'(b)) csb_issue[b] = 1'b0;
  end

  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NBANK; b++)
      if (bank_q == 3'(b)) rd_sel = ram_rdata_i[b*DW +: DW];
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= 2'd0;
      bank_q      <= 3'd0;
      grant_la_q  <= 1'b0;
      wb_abort_q  <= 1'b0;
      favour_la   <= 1'b0;
      ram_csb1_o  <= '1;
      ram_addr1_o <= '0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      la_ack_o    <= 1'b0;
      la_rdata_o  <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      la_ack_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_la | grant_wb) begin
            bank_q     <= sel_bank;
            grant_la_q <= grant_la;
            wb_abort_q <= 1'b0;
            favour_la  <= grant_wb;
            // Writes and out-of-range banks answer zero without touching the macros
            if (sel_fast) begin
              state <= S_RESP;
              if (grant_la) begin
                la_ack_o   <= 1'b1;
                la_rdata_o <= '0;
              end else begin
                wbs_ack_o <= 1'b1;
                wbs_dat_o <= 32'd0;
              end
            end else begin
              state       <= S_ISSUE;
              ram_csb1_o  <= csb_issue;
              ram_addr1_o <= sel_word;
            end
          end
        end
        S_ISSUE: begin
          ram_csb1_o <= '1;
          wait_cnt   <= WAIT_INIT;
          state      <= S_WAIT;
          if (!wbs_cyc_i) wb_abort_q <= 1'b1;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (!wbs_cyc_i) wb_abort_q <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      // A WB master that abandoned the cycle gets no ack and keeps its old data
      if (complete) begin
        state <= S_RESP;
        if (grant_la_q) begin
          la_ack_o   <= 1'b1;
          la_rdata_o <= rd_sel;
        end else if (!wb_abort_q && wbs_cyc_i) begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= 32'(rd_sel);
        end
      end
    end
  end

endmodule
